// File: rtl/msg_ram_checker_pkg.sv
// Shared types and helpers for the decrypted-message RAM checker.
// Contents: FSM state enum, character constants, is_legal_char().
package msg_chk_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADDR  = 3'd1,
      WAIT  = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4
   } state_e;

   localparam logic [7:0] CHAR_SPACE = 8'h20;
   localparam logic [7:0] CHAR_A_LO  = 8'h61;
   localparam logic [7:0] CHAR_Z_LO  = 8'h7A;

   // Legal plaintext: lowercase letters or a single space.
   function automatic bit is_legal_char(input logic [7:0] c);
      return ((c >= CHAR_A_LO) && (c <= CHAR_Z_LO)) || (c == CHAR_SPACE);
   endfunction

endpackage

// File: rtl/msg_ram_checker_if.sv
// RAM read-port and status bundle between the checker and its environment.
// master : checker side (drives address/done/pass[/bad_index], reads start/q)
// slave  : environment side (RAM + key controller)
// Optional: MSG_CHK_CAPTURE_EN adds bad_index.
interface msg_ram_checker_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              start;
   logic [7:0]        q;
   logic [ADDR_W-1:0] address;
   logic              done;
   logic              pass;
`ifdef MSG_CHK_CAPTURE_EN
   logic [ADDR_W-1:0] bad_index;
`endif

   modport master (
      input  start,
      input  q,
      output address,
      output done,
      output pass
`ifdef MSG_CHK_CAPTURE_EN
      , output bad_index
`endif
   );

   modport slave (
      output start,
      output q,
      input  address,
      input  done,
      input  pass
`ifdef MSG_CHK_CAPTURE_EN
      , input bad_index
`endif
   );
endinterface

// File: rtl/msg_ram_checker.sv
// Walks the decrypted-message RAM from 0..MSG_LEN-1 and reports whether every
// byte is legal plaintext, stopping at the first illegal byte.
// Ports: clk, reset_n (async, active-low), bus (msg_ram_checker_if.master):
//   start in, q in, address out, done out, pass out, bad_index out (optional).
// Optional: MSG_CHK_CAPTURE_EN records the terminal index in bad_index.
module msg_ram_checker
   import msg_chk_pkg::*;
#(
   parameter int unsigned MSG_LEN = 32,
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned RD_LAT  = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   msg_ram_checker_if.master   bus
);

   localparam int unsigned       CNT_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(MSG_LEN - 1);
   localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'(RD_LAT - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
`ifdef MSG_CHK_CAPTURE_EN
   logic [ADDR_W-1:0] bad_q, bad_d;
`endif

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         addr_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
`ifdef MSG_CHK_CAPTURE_EN
         bad_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
`ifdef MSG_CHK_CAPTURE_EN
         bad_q   <= bad_d;
`endif
      end
   end

   // Next-state logic. address is loaded on entry to ADDR so it is already
   // valid for the whole ADDR/WAIT/CHECK span of each byte.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      pass_d  = pass_q;
`ifdef MSG_CHK_CAPTURE_EN
      bad_d   = bad_q;
`endif
      case (state_q)
         IDLE: begin
            done_d = 1'b0;
            if (bus.start) begin
               idx_d   = '0;
               addr_d  = '0;
               state_d = ADDR;
            end
         end
         ADDR: begin
            addr_d  = idx_q;
            cnt_d   = WAIT_INIT;
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == '0) state_d = CHECK;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         CHECK: begin
            if (!is_legal_char(bus.q)) begin
               pass_d  = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
`ifdef MSG_CHK_CAPTURE_EN
               bad_d   = idx_q;
`endif
            end else if (idx_q == LAST_IDX) begin
               // Terminal compare keeps idx from ever wrapping.
               pass_d  = 1'b1;
               done_d  = 1'b1;
               state_d = DONE;
`ifdef MSG_CHK_CAPTURE_EN
               bad_d   = LAST_IDX;
`endif
            end else begin
               idx_d   = idx_q + ADDR_W'(1);
               addr_d  = idx_q + ADDR_W'(1);
               state_d = ADDR;
            end
         end
         DONE: begin
            // Only a sampled low start rearms; a held start never retriggers.
            if (!bus.start) begin
               done_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.address = addr_q;
   assign bus.done    = done_q;
   assign bus.pass    = pass_q;
`ifdef MSG_CHK_CAPTURE_EN
   assign bus.bad_index = bad_q;
`endif

endmodule
